// File: rtl/prores_slice_parser.sv
// ProRes slice parser: reads the slice header, then routes the payload bytes
// to the Y, Cb and Cr decoders with per-component framing.
module prores_slice_parser #(
  parameter int unsigned MIN_HDR_BYTES = 6,
  parameter int unsigned Y_BLOCKS      = 32,
  parameter int unsigned C_BLOCKS      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        slice_start,
  input  logic [15:0] slice_size,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_component,
  output logic        out_last,
  output logic        is_y,
  output logic [31:0] block_num,
  output logic [7:0]  header_size,
  output logic [7:0]  qscale,
  output logic [15:0] y_size,
  output logic [15:0] cb_size,
  output logic [15:0] cr_size,
  output logic        header_valid,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, HDR, SKIP, Y, CB, CR, DONE, DRAIN} state_t;

  localparam logic [15:0] FIXED_HDR = 16'd6;
  localparam logic [7:0]  MIN_HDR   = MIN_HDR_BYTES[7:0];

  state_t      state, state_nxt;
  logic [15:0] rem, bcnt, slice_sz, cur_size, cb_full, cr_calc;
  logic [17:0] hdr_sum;
  logic [7:0]  skip_end;
  logic [1:0]  cur_comp;
  logic        acc, load, last_byte, hdr_err;

  // cb_size low byte arrives with the final fixed header byte, so checks use it directly
  assign cb_full   = {cb_size[15:8], in_data};
  assign hdr_sum   = 18'(header_size) + 18'(y_size) + 18'(cb_full);
  assign hdr_err   = (header_size < MIN_HDR) || (hdr_sum > 18'(slice_sz));
  assign cr_calc   = slice_sz - 16'(header_size) - y_size - cb_full;
  assign skip_end  = header_size - 8'd7;
  assign last_byte = (bcnt == cur_size - 16'd1);
  assign acc       = in_valid && in_ready;
  assign load      = acc && (state == Y || state == CB || state == CR);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (slice_start) begin
               if (slice_size == 16'd0)          state_nxt = DONE;
               else if (slice_size < FIXED_HDR)  state_nxt = DRAIN;
               else                              state_nxt = HDR;
             end
      HDR:   if (acc && bcnt == 16'd5)
               state_nxt = hdr_err ? DRAIN : ((header_size > 8'd6) ? SKIP : Y);
      SKIP:  if (acc && bcnt == 16'(skip_end)) state_nxt = Y;
      Y:     if (cur_size == 16'd0 || (acc && last_byte)) state_nxt = CB;
      CB:    if (cur_size == 16'd0 || (acc && last_byte)) state_nxt = CR;
      CR:    if (cur_size == 16'd0 || (acc && last_byte)) state_nxt = DONE;
      DONE:  if (!out_valid) state_nxt = IDLE;
      DRAIN: if (rem == 16'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // empty components and an exhausted drain refuse bytes so nothing is lost
  always_comb begin
    in_ready = 1'b0;
    cur_size = 16'd0;
    cur_comp = 2'd0;
    case (state)
      HDR, SKIP: in_ready = 1'b1;
      DRAIN:     in_ready = (rem != 16'd0);
      Y:         begin cur_size = y_size;  cur_comp = 2'd0; end
      CB:        begin cur_size = cb_size; cur_comp = 2'd1; end
      CR:        begin cur_size = cr_size; cur_comp = 2'd2; end
      default: ;
    endcase
    if (state == Y || state == CB || state == CR)
      in_ready = (cur_size != 16'd0) && (!out_valid || out_ready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0; bcnt <= '0; slice_sz <= '0;
      out_data <= '0; out_valid <= 1'b0; out_component <= 2'd0; out_last <= 1'b0;
      is_y <= 1'b1; block_num <= Y_BLOCKS;
      header_size <= '0; qscale <= '0; y_size <= '0; cb_size <= '0; cr_size <= '0;
      header_valid <= 1'b0; done <= 1'b0; error <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      done         <= 1'b0;
      if (state != state_nxt) bcnt <= '0;
      else if (acc)           bcnt <= bcnt + 16'd1;
      if (acc) rem <= rem - 16'd1;
      case (state)
        IDLE: if (slice_start) begin
                rem      <= slice_size;
                slice_sz <= slice_size;
                error    <= (slice_size < FIXED_HDR);
              end
        HDR: if (acc) begin
               case (bcnt[2:0])
                 3'd0: header_size   <= {3'b000, in_data[7:3]};
                 3'd1: qscale        <= in_data;
                 3'd2: y_size[15:8]  <= in_data;
                 3'd3: y_size[7:0]   <= in_data;
                 3'd4: cb_size[15:8] <= in_data;
                 default: begin
                   cb_size[7:0] <= in_data;
                   if (hdr_err) error <= 1'b1;
                   else begin
                     cr_size      <= cr_calc;
                     header_valid <= 1'b1;
                   end
                 end
               endcase
             end
        DONE:  if (!out_valid) done <= 1'b1;
        DRAIN: if (rem == 16'd0) done <= 1'b1;
        default: ;
      endcase
      if (load) begin
        out_data      <= in_data;
        out_component <= cur_comp;
        out_last      <= last_byte;
        is_y          <= (state == Y);
        block_num     <= (state == Y) ? Y_BLOCKS : C_BLOCKS;
        out_valid     <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
